// File: rtl/lane_gather_buffer.sv
// lane_gather_buffer: collects per-lane router bytes over several beats, then hands one packed vector to the PE array
module lane_gather_buffer #(
  parameter int LANES = 16,
  parameter int DATA_W = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LANES-1:0]          lane_mask,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic [LANES-1:0]          in_lane_valid,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [LANES-1:0]          out_lane_valid,
  output logic [7:0]                out_beats,
  output logic                      busy,
  output logic                      timeout_err
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, GATHER, OUTPUT} state_t;
  state_t state;
  logic [LANES-1:0] mask, new_cap, all_cap;
  logic [TW-1:0] tcnt;
  logic [LANES*DATA_W-1:0] merged;
  logic accept;
  assign in_ready = state == GATHER;
  assign out_valid = state == OUTPUT;
  assign busy = state != IDLE;
  // lanes captured by this beat: requested, offered, and not already held (first write wins)
  always_comb begin
    accept = in_valid & (state == GATHER);
    new_cap = accept ? in_lane_valid & mask & ~out_lane_valid : '0;
    all_cap = out_lane_valid | new_cap;
    merged = out_data;
    for (int i = 0; i < LANES; i++)
      if (new_cap[i]) merged[i*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
  end
  // gather state machine with capture registers, beat counter and stall timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mask <= '0;
      out_data <= '0;
      out_lane_valid <= '0;
      out_beats <= '0;
      tcnt <= '0;
      timeout_err <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        mask <= lane_mask;
        out_data <= '0;
        out_lane_valid <= '0;
        out_beats <= '0;
        tcnt <= '0;
        timeout_err <= 1'b0;
        state <= lane_mask == '0 ? OUTPUT : GATHER;
      end
    end else if (state == GATHER) begin
      out_data <= merged;
      out_lane_valid <= all_cap;
      if (accept && out_beats != 8'hFF) out_beats <= out_beats + 8'd1;
      tcnt <= |new_cap ? '0 : tcnt + 1'b1;
      if (all_cap == mask) state <= OUTPUT;
      else if (!(|new_cap) && tcnt == TW'(TIMEOUT - 1)) begin
        state <= OUTPUT;
        timeout_err <= 1'b1;
      end
    end else if (out_ready) state <= IDLE;
  end
endmodule

// File: tb/tb_lane_gather_buffer.sv
// tb_lane_gather_buffer: directed scenarios plus random traffic checked every cycle against a lane-level model
module tb_lane_gather_buffer;
  localparam int L = 16, W = 8, TO = 8;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
  logic [L-1:0] lane_mask = '0, in_lane_valid = '0;
  logic [L*W-1:0] in_data = '0;
  logic in_ready, out_valid, busy, timeout_err;
  logic [L*W-1:0] out_data;
  logic [L-1:0] out_lane_valid;
  logic [7:0] out_beats;
  int pass_cnt = 0, total = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  lane_gather_buffer #(.LANES(L), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .lane_mask(lane_mask),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_lane_valid(in_lane_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane_valid(out_lane_valid), .out_beats(out_beats), .busy(busy), .timeout_err(timeout_err));
  // model: phase 0 waiting, 1 collecting, 2 presenting; per-lane byte and flag arrays
  int ph = 0, mbeats = 0, idle_run = 0;
  bit merr = 0;
  bit [7:0] mb[L];
  bit mv[L], mm[L];
  function automatic logic [127:0] exp_data();
    logic [127:0] r = '0;
    for (int i = 0; i < L; i++) r[i*W +: W] = mb[i];
    return r;
  endfunction
  function automatic logic [127:0] exp_lanes();
    logic [127:0] r = '0;
    for (int i = 0; i < L; i++) r[i] = mv[i];
    return r;
  endfunction
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  always @(posedge clk) begin
    int got;
    bit done;
    if (rst) begin
      ph = 0; mbeats = 0; idle_run = 0; merr = 0;
      for (int i = 0; i < L; i++) begin mb[i] = 0; mv[i] = 0; mm[i] = 0; end
    end else if (ph == 0) begin
      if (start) begin
        for (int i = 0; i < L; i++) begin mb[i] = 0; mv[i] = 0; mm[i] = lane_mask[i]; end
        mbeats = 0; idle_run = 0; merr = 0;
        ph = lane_mask == 0 ? 2 : 1;
      end
    end else if (ph == 1) begin
      got = 0;
      if (in_valid) begin
        for (int i = 0; i < L; i++)
          if (in_lane_valid[i] && mm[i] && !mv[i]) begin mv[i] = 1; mb[i] = in_data[i*W +: W]; got++; end
        if (mbeats < 255) mbeats++;
      end
      done = 1;
      for (int i = 0; i < L; i++) if (mv[i] != mm[i]) done = 0;
      if (got > 0) idle_run = 0; else idle_run++;
      if (done) ph = 2;
      else if (idle_run == TO) begin merr = 1; ph = 2; end
    end else if (out_ready) ph = 0;
  end
  // every-cycle comparison of all outputs against the model
  always @(negedge clk) if (chk_en) begin
    check("data", out_data, exp_data());
    check("lanes", out_lane_valid, exp_lanes());
    check("beats", out_beats, mbeats);
    check("flags", {in_ready, out_valid, busy, timeout_err}, {ph == 1, ph == 2, ph != 0, merr});
  end
  task automatic go(input logic [15:0] m);
    @(posedge clk); #2 start = 1; lane_mask = m;
    @(posedge clk); #2 start = 0;
  endtask
  task automatic beat(input logic [15:0] lv, input logic [127:0] d);
    in_valid = 1; in_lane_valid = lv; in_data = d;
    @(posedge clk); #2 in_valid = 0; in_lane_valid = '0;
  endtask
  task automatic drain();
    out_ready = 1;
    @(posedge clk); #2 out_ready = 0;
  endtask
  initial begin
    logic [127:0] d;
    int n;
    repeat (2) @(posedge clk);
    #2 rst = 0; chk_en = 1;
    check("rst_ctrl", {out_valid, busy, in_ready, timeout_err, out_beats, out_lane_valid}, '0);
    check("rst_data", out_data, '0);
    go(16'hFFFF);
    beat(16'hFFFF, 128'h112233445566778899AABBCCDDEEFF00);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 128'h112233445566778899AABBCCDDEEFF00);
    check("t1_lanes", out_lane_valid, 16'hFFFF);
    check("t1_beats", out_beats, 1);
    drain();
    go(16'hFFFF);
    beat(16'h00FF, {16{8'hAA}});
    beat(16'hFF01, {16{8'h55}});
    check("t2_data", out_data, 128'h5555555555555555AAAAAAAAAAAAAAAA);
    check("t2_beats", out_beats, 2);
    drain();
    go(16'h0003);
    beat(16'hFFFF, {16{8'h77}});
    check("t3_data", out_data, 128'h7777);
    check("t3_lanes", out_lane_valid, 16'h0003);
    drain();
    d = {$urandom, $urandom, $urandom, $urandom};
    go(16'hFFFF);
    beat(16'hFFFF, d);
    repeat (5) begin
      start = 1; in_valid = 1; in_lane_valid = '1; in_data = ~d;
      @(posedge clk); #2;
      check("t4_hold", {out_valid, in_ready}, 2'b10);
      check("t4_data", out_data, d);
    end
    start = 0; in_valid = 0; in_lane_valid = '0;
    drain();
    check("t4_idle", {busy, out_valid}, 2'b00);
    go(16'hFFFF);
    beat(16'h7FFF, {16{8'h3C}});
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #2 n++; end
    check("t5_delay", n, TO);
    check("t5_err", timeout_err, 1);
    check("t5_lanes", out_lane_valid, 16'h7FFF);
    drain();
    go(16'hFFFF);
    check("t5_clear", timeout_err, 0);
    beat(16'hFFFF, {16{8'h01}});
    drain();
    go(16'hFFFF);
    beat(16'h000F, {16{8'h11}});
    rst = 1;
    @(posedge clk); #2 rst = 0;
    check("t6_rst", {busy, out_valid, timeout_err, out_beats, out_lane_valid}, '0);
    check("t6_data", out_data, '0);
    go(16'hFFFF);
    beat(16'hFFF0, {16{8'h22}});
    beat(16'h000F, {16{8'h33}});
    check("t6_fresh", out_data, {{12{8'h22}}, {4{8'h33}}});
    check("t6_beats", out_beats, 2);
    drain();
    repeat (3000) begin
      start = $urandom % 4 == 0;
      case ($urandom % 8)
        0: lane_mask = '0;
        1: lane_mask = 16'(1 << ($urandom % 16));
        default: lane_mask = 16'($urandom);
      endcase
      in_valid = $urandom % 2;
      in_lane_valid = 16'($urandom & $urandom);
      in_data = {$urandom, $urandom, $urandom, $urandom};
      out_ready = $urandom % 3 != 0;
      rst = $urandom % 300 == 0;
      @(posedge clk); #2;
    end
    rst = 0; start = 0; in_valid = 0; out_ready = 0;
    @(posedge clk); #2;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
